// File: rtl/horn_wavegen.sv
// horn_wavegen: push-button tone generator driving an R2R DAC from a phase accumulator.
// Saw / triangle / square / two-tone warble; a release lets the current waveform cycle finish.
module horn_wavegen #(
  parameter int DAC_W           = 8,
  parameter int ACC_W           = 24,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WARBLE_CYCLES   = 12500000
) (
  input  logic             c50M,
  input  logic             Reset,
  input  logic             Button,
  input  logic [1:0]       Mode,
  input  logic [ACC_W-1:0] TuneWord,
  output logic [DAC_W-1:0] OutputToDAC,
  output logic             Active
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int WCW = (WARBLE_CYCLES > 1) ? $clog2(WARBLE_CYCLES) : 1;
  localparam logic [DAC_W-1:0] MIDSCALE = {1'b1, {(DAC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SOUNDING, STOPPING} state_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [ACC_W-1:0] tune;
  } cfg_t;

  state_t           state, nxt;
  cfg_t             cfg;
  logic [1:0]       sync;
  logic [DBW-1:0]   db_cnt;
  logic             pressed;
  logic [ACC_W-1:0] acc, inc;
  logic [ACC_W:0]   sum;
  logic             wrap;
  logic [WCW-1:0]   wcnt;
  logic             low_tone;
  logic [DAC_W-1:0] saw, tri_w, wave;

  // Button: 2-FF synchroniser, then a level debouncer that needs an unbroken run of disagreement.
  always_ff @(posedge c50M or posedge Reset) begin
    if (Reset) begin
      sync    <= '0;
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], Button};
      if (sync[1] == pressed) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt  <= '0;
        pressed <= ~pressed;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign inc  = (cfg.mode == 2'd3 && low_tone) ? (cfg.tune >> 1) : cfg.tune;
  assign sum  = {1'b0, acc} + {1'b0, inc};
  assign wrap = sum[ACC_W];

  always_ff @(posedge c50M or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  // A wrap coinciding with the release in SOUNDING is deliberately ignored.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (pressed) nxt = SOUNDING;
      SOUNDING: if (!pressed) nxt = STOPPING;
      STOPPING: begin
        if (pressed)                         nxt = SOUNDING;
        else if (wrap || cfg.tune == '0)     nxt = IDLE;
      end
      default:  nxt = IDLE;
    endcase
  end

  assign saw   = acc[ACC_W-1 -: DAC_W];
  assign tri_w = acc[ACC_W-2 -: DAC_W];

  always_comb begin
    Active = (state != IDLE);
    case (cfg.mode)
      2'd1:    wave = acc[ACC_W-1] ? ~tri_w : tri_w;
      2'd2:    wave = {DAC_W{acc[ACC_W-1]}};
      default: wave = saw;
    endcase
  end

  // Config is frozen for the whole sound, including STOPPING -> SOUNDING re-presses.
  always_ff @(posedge c50M or posedge Reset) begin
    if (Reset) begin
      cfg         <= '0;
      acc         <= '0;
      wcnt        <= '0;
      low_tone    <= 1'b0;
      OutputToDAC <= MIDSCALE;
    end else if (state == IDLE) begin
      if (pressed) begin
        cfg.mode <= Mode;
        cfg.tune <= TuneWord;
      end
      acc         <= '0;
      wcnt        <= '0;
      low_tone    <= 1'b0;
      OutputToDAC <= MIDSCALE;
    end else begin
      acc         <= sum[ACC_W-1:0];
      OutputToDAC <= wave;
      if (wcnt == WCW'(WARBLE_CYCLES - 1)) begin
        wcnt     <= '0;
        low_tone <= ~low_tone;
      end else begin
        wcnt <= wcnt + WCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_horn_wavegen.sv
// Randomised scoreboard bench for horn_wavegen: a per-cycle reference model queues expected
// DAC code / Active; a monitor pops and compares one entry after every rising edge.
module tb_horn_wavegen;

  localparam int DW   = 8;
  localparam int AW   = 9;
  localparam int DB   = 4;
  localparam int WB   = 600;
  localparam int MID  = 1 << (DW - 1);
  localparam int FULL = 1 << AW;
  localparam int DMAX = (1 << DW) - 1;
  localparam int S_IDLE = 0, S_SND = 1, S_STOP = 2;

  logic          c50M = 1'b0;
  logic          Reset = 1'b1;
  logic          Button = 1'b0;
  logic [1:0]    Mode = '0;
  logic [AW-1:0] TuneWord = '0;
  logic [DW-1:0] OutputToDAC;
  logic          Active;

  horn_wavegen #(.DAC_W(DW), .ACC_W(AW), .DEBOUNCE_CYCLES(DB), .WARBLE_CYCLES(WB)) dut (
    .c50M(c50M), .Reset(Reset), .Button(Button), .Mode(Mode), .TuneWord(TuneWord),
    .OutputToDAC(OutputToDAC), .Active(Active)
  );

  always #5 c50M = ~c50M;

  typedef struct {
    logic [DW-1:0] dac;
    logic          act;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   running = 0;

  // Reference model state
  bit hist[$];
  bit m_deb;
  int m_st, m_phase, m_act, m_mode, m_tune;
  int last_dac;
  int g_mode, g_tune;

  function automatic int wave(int ph, int md);
    if (md == 1) return (ph < FULL/2) ? (ph >> (AW-1-DW)) : ((FULL-1-ph) >> (AW-1-DW));
    if (md == 2) return (ph >= FULL/2) ? DMAX : 0;
    return ph >> (AW-DW);
  endfunction

  task automatic m_reset();
    hist.delete();
    for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
    m_deb = 0; m_st = S_IDLE; m_phase = 0; m_act = 0; m_mode = 0; m_tune = 0;
  endtask

  // One rising edge of the model, using the inputs that edge will see.
  task automatic step(bit btn, int md, int tw, bit rst);
    exp_t e;
    int inc, nst;
    bit wrap, flip;
    if (rst) begin
      m_reset();
      e.dac = MID[DW-1:0]; e.act = 1'b0;
      last_dac = MID;
      sbq.push_back(e);
      return;
    end
    hist.push_back(btn);
    // debounced level flips once the last DB synced samples (2 edges late) all disagree
    flip = 1;
    for (int j = 2; j <= DB + 1; j++) if (hist[hist.size()-1-j] == m_deb) flip = 0;
    inc  = (m_mode == 3 && ((m_act / WB) % 2) == 1) ? (m_tune / 2) : m_tune;
    wrap = (m_phase + inc) >= FULL;
    e.dac = (m_st == S_IDLE) ? MID[DW-1:0] : wave(m_phase, m_mode);
    nst = m_st;
    if (m_st == S_IDLE) begin
      if (m_deb) begin nst = S_SND; m_mode = md; m_tune = tw; end
    end else if (m_st == S_SND) begin
      if (!m_deb) nst = S_STOP;
    end else begin
      if (m_deb) nst = S_SND;
      else if (wrap || m_tune == 0) nst = S_IDLE;
    end
    if (m_st == S_IDLE) begin m_phase = 0; m_act = 0; end
    else begin m_phase = (m_phase + inc) % FULL; m_act++; end
    if (flip) m_deb = ~m_deb;
    m_st = nst;
    e.act = (nst != S_IDLE);
    last_dac = e.dac;
    while (hist.size() > DB + 4) void'(hist.pop_front());
    sbq.push_back(e);
  endtask

  task automatic drive(bit b, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge c50M);
      Reset = 1'b0; Button = b; Mode = g_mode[1:0]; TuneWord = g_tune[AW-1:0];
      step(b, g_mode, g_tune, 1'b0);
      running = 1;
    end
  endtask

  task automatic rst_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge c50M);
      Reset = 1'b1; Mode = g_mode[1:0]; TuneWord = g_tune[AW-1:0];
      step(Button, g_mode, g_tune, 1'b1);
      running = 1;
    end
  endtask

  task automatic wait_idle(int maxc);
    int n;
    n = 0;
    while (m_st != S_IDLE && n < maxc) begin drive(1'b0, 1); n++; end
    if (m_st != S_IDLE) begin
      tests++; fails++;
      $display("FAIL wait_idle: still sounding after %0d cycles, required idle", maxc);
    end
    drive(1'b0, 3);
  endtask

  task automatic bounce(int segs);
    for (int i = 0; i < segs; i++) drive(1'($urandom_range(0, 1)), $urandom_range(1, 3));
  endtask

  // Monitor: one expected entry per rising edge once stimulus is running.
  exp_t me;
  always @(posedge c50M) begin
    #1;
    if (running) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: DAC sample with empty queue at %0t", $time);
      end else begin
        me = sbq.pop_front();
        if (OutputToDAC !== me.dac || Active !== me.act) begin
          fails++;
          if (fails <= 25)
            $display("FAIL dac_active t=%0t got dac=%0d act=%0b required dac=%0d act=%0b",
                     $time, OutputToDAC, Active, me.dac, me.act);
        end
      end
    end
  end

  initial begin
    int guard;
    g_mode = 0; g_tune = 2;
    m_reset();
    rst_cycles(3);
    drive(1'b0, 5);

    // saw, full ramp twice, then stop
    g_mode = 0; g_tune = 2;
    drive(1'b1, 600);
    wait_idle(1000);

    // triangle and square, one period plus
    g_mode = 1; g_tune = 1;
    drive(1'b1, 1100);
    wait_idle(1000);
    g_mode = 2; g_tune = 1;
    drive(1'b1, 1100);
    wait_idle(1000);

    // short glitches must be rejected, a 10-cycle press accepted
    g_mode = 0; g_tune = 64;
    drive(1'b1, 1); drive(1'b0, 10);
    drive(1'b1, 2); drive(1'b0, 10);
    drive(1'b1, 3); drive(1'b0, 10);
    drive(1'b1, 10);
    wait_idle(1000);

    // clean stop at output 100, then re-press during STOPPING
    g_mode = 0; g_tune = 2;
    guard = 0;
    drive(1'b1, 1);
    while (!(m_st == S_SND && last_dac == 100) && guard < 2000) begin drive(1'b1, 1); guard++; end
    drive(1'b0, 20);
    drive(1'b1, 100);
    drive(1'b0, 1);
    wait_idle(1000);

    // warble, with ignored Mode/TuneWord changes mid-sound
    g_mode = 3; g_tune = 4;
    drive(1'b1, 300);
    g_mode = 1; g_tune = 100;
    drive(1'b1, 2200);
    g_mode = 3; g_tune = 4;
    wait_idle(2000);

    // reset mid-sound at output 0x37: outputs must drop before the next edge
    g_mode = 0; g_tune = 2;
    guard = 0;
    drive(1'b1, 1);
    while (!(m_st == S_SND && last_dac == 'h37) && guard < 2000) begin drive(1'b1, 1); guard++; end
    @(posedge c50M); #2;
    Reset = 1'b1;
    #1;
    tests++;
    if (OutputToDAC !== MID[DW-1:0] || Active !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got dac=%0d act=%0b required dac=%0d act=0", OutputToDAC, Active, MID);
    end
    rst_cycles(2);
    drive(1'b1, 30);
    wait_idle(1000);

    // TuneWord 0: silent at wave(0), idle right after debounced release
    g_mode = 0; g_tune = 0;
    drive(1'b1, 20);
    wait_idle(50);

    // random episodes: bouncy press, random hold, mid-sound input noise, bouncy release
    for (int ep = 0; ep < 14; ep++) begin
      g_mode = $urandom_range(0, 3);
      g_tune = $urandom_range(0, FULL - 1);
      bounce(4);
      drive(1'b1, $urandom_range(8, 400));
      g_mode = $urandom_range(0, 3);
      g_tune = $urandom_range(0, FULL - 1);
      drive(1'b1, $urandom_range(1, 400));
      bounce(3);
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b0, $urandom_range(6, 20));
        drive(1'b1, $urandom_range(8, 100));
      end
      wait_idle(3000);
    end

    drive(1'b0, 2);
    @(posedge c50M); #3;
    running = 0;
    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
